// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the single-port RAM arbiter.
package ram_arb_pkg;

    localparam int DEF_NREQ   = 2;
    localparam int DEF_AW     = 8;
    localparam int DEF_DW     = 8;
    localparam int DEF_RD_LAT = 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = clog2(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   win_idx,
    output logic            any
);

    always_comb begin
        int              idx;
        logic [NREQ-1:0] shifted;
        idx     = 0;
        shifted = '0;
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            idx     = (int'(ptr) + off) % NREQ;
            shifted = req >> idx;
            if (!any && shifted[0]) begin
                any     = 1'b1;
                win     = NREQ'(1) << idx;
                win_idx = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between NREQ requesters.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [DW-1:0]     rdata,
    output logic              busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_wdata,
    input  logic [DW-1:0]     ram_rdata
);

    localparam int PW = clog2(NREQ);
    localparam int CW = clog2(RD_LAT) + 1;

    state_t          state, state_next;
    logic [PW-1:0]   ptr, ptr_next;
    logic [PW-1:0]   cur_idx, cur_idx_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [NREQ-1:0] win;
    logic [PW-1:0]   win_idx;
    logic            any;

    logic [NREQ-1:0] gnt_next, ack_next;
    logic [DW-1:0]   rdata_next, ram_wdata_next;
    logic [AW-1:0]   ram_addr_next;
    logic            busy_next, ram_en_next, ram_we_next;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx),
        .any     (any)
    );

    // Every output is computed here one cycle ahead and registered below.
    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        cur_idx_next   = cur_idx;
        cnt_next       = cnt;
        gnt_next       = gnt;
        ack_next       = '0;
        rdata_next     = rdata;
        ram_en_next    = 1'b0;
        ram_we_next    = 1'b0;
        ram_addr_next  = ram_addr;
        ram_wdata_next = ram_wdata;
        case (state)
            IDLE: begin
                gnt_next = '0;
                if (any) begin
                    state_next     = ISSUE;
                    gnt_next       = win;
                    cur_idx_next   = win_idx;
                    ram_en_next    = 1'b1;
                    ram_we_next    = req_we[win_idx];
                    ram_addr_next  = req_addr[int'(win_idx)*AW +: AW];
                    ram_wdata_next = req_wdata[int'(win_idx)*DW +: DW];
                end
            end
            ISSUE: begin
                if (ram_we) begin
                    state_next = ACK;
                    ack_next   = gnt;
                end else begin
                    state_next = WAIT;
                    cnt_next   = CW'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    rdata_next = ram_rdata;
                    state_next = ACK;
                    ack_next   = gnt;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ACK: begin
                state_next = IDLE;
                gnt_next   = '0;
                ptr_next   = (int'(cur_idx) == NREQ - 1) ? '0 : cur_idx + 1'b1;
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cur_idx   <= '0;
            cnt       <= '0;
            gnt       <= '0;
            ack       <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            cur_idx   <= cur_idx_next;
            cnt       <= cnt_next;
            gnt       <= gnt_next;
            ack       <= ack_next;
            rdata     <= rdata_next;
            busy      <= busy_next;
            ram_en    <= ram_en_next;
            ram_we    <= ram_we_next;
            ram_addr  <= ram_addr_next;
            ram_wdata <= ram_wdata_next;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized self-checking bench for ram_port_arbiter (NREQ=4, RD_LAT=3) with a behavioural RAM.
module tb_ram_port_arbiter;

    localparam int NREQ   = 4;
    localparam int AW     = 8;
    localparam int DW     = 8;
    localparam int RD_LAT = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req, req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt, ack;
    logic [DW-1:0]      rdata;
    logic               busy, ram_en, ram_we;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_wdata, ram_rdata;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] pipe [RD_LAT];

    // Reference model state
    int            model_ptr;
    logic [DW-1:0] ref_mem [256];
    bit            pend [NREQ];
    logic          p_we [NREQ];
    logic [AW-1:0] p_addr [NREQ];
    logic [DW-1:0] p_data [NREQ];
    int            waits [NREQ];
    int            grants [NREQ];
    int            checks = 0;
    int            errors = 0;

    ram_port_arbiter #(
        .NREQ   (NREQ),
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: data appears RD_LAT edges after the strobe; non-strobed slots carry inverted data
    assign ram_rdata = pipe[RD_LAT-1];
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        pipe[0] <= ram_en ? mem[ram_addr] : ~mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

    function automatic logic [NREQ-1:0] onehot(input int i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    task automatic raise(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i]   = 1'b1;
        p_we[i]   = we;
        p_addr[i] = a;
        p_data[i] = d;
        waits[i]  = 0;
        req[i]    = 1'b1;
        req_we[i] = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic raise_random(input int i);
        logic [AW-1:0] a;
        a = ($urandom_range(0, 1) == 0) ? 8'h05 : AW'(8'h10 + $urandom_range(0, 3));
        raise(i, 1'($urandom_range(0, 1)), a, DW'($urandom));
    endtask

    // Call from an IDLE cycle; the next edge samples requests.
    task automatic run_txn(input string name, input int drop_at, output int w);
        int n, exp_n;
        bit seen;
        w = -1;
        for (int off = 0; off < NREQ; off++)
            if (w < 0 && pend[(model_ptr + off) % NREQ]) w = (model_ptr + off) % NREQ;
        if (w < 0) begin
            errors++;
            $display("[TB] FAIL %s: no pending requester in model", name);
            return;
        end
        exp_n = p_we[w] ? 2 : 2 + RD_LAT;

        @(posedge clk); #1; n = 1;
        checks++;
        if (gnt !== onehot(w) || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s issue_gnt: gnt=%b busy=%b required gnt=%b busy=1", name, gnt, busy, onehot(w));
        end
        checks++;
        if (ram_en !== 1'b1 || ram_we !== p_we[w] || ram_addr !== p_addr[w] || ram_wdata !== p_data[w]) begin
            errors++;
            $display("[TB] FAIL %s issue_ram: en=%b we=%b addr=%h wdata=%h required 1 %b %h %h",
                     name, ram_en, ram_we, ram_addr, ram_wdata, p_we[w], p_addr[w], p_data[w]);
        end
        // Change the winner's request fields; the arbiter must use the latched copy.
        req_we[w] = ~req_we[w];
        req_addr[w*AW +: AW]  = AW'($urandom);
        req_wdata[w*DW +: DW] = DW'($urandom);

        seen = 1'b0;
        while (!seen && n < exp_n + 4) begin
            if (n == drop_at) req[w] = 1'b0;
            @(posedge clk); #1; n++;
            if (ack !== '0) seen = 1'b1;
            else begin
                checks++;
                if (gnt !== onehot(w) || ram_en !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s hold: cycle %0d gnt=%b ram_en=%b required gnt=%b ram_en=0",
                             name, n, gnt, ram_en, onehot(w));
                end
            end
        end
        checks++;
        if (!seen || n != exp_n) begin
            errors++;
            $display("[TB] FAIL %s latency: ack seen=%0d at cycle %0d required cycle %0d", name, seen, n, exp_n);
        end
        checks++;
        if (ack !== onehot(w) || gnt !== onehot(w)) begin
            errors++;
            $display("[TB] FAIL %s ack: ack=%b gnt=%b required %b", name, ack, gnt, onehot(w));
        end
        if (!p_we[w]) begin
            checks++;
            if (rdata !== ref_mem[p_addr[w]]) begin
                errors++;
                $display("[TB] FAIL %s rdata: got %h required %h", name, rdata, ref_mem[p_addr[w]]);
            end
        end

        if (p_we[w]) ref_mem[p_addr[w]] = p_data[w];
        for (int i = 0; i < NREQ; i++) begin
            if (i != w && pend[i]) begin
                waits[i]++;
                checks++;
                if (waits[i] > NREQ - 1) begin
                    errors++;
                    $display("[TB] FAIL %s starvation: req %0d waited %0d grants, limit %0d", name, i, waits[i], NREQ - 1);
                end
            end
        end
        pend[w]   = 1'b0;
        waits[w]  = 0;
        req[w]    = 1'b0;
        grants[w] = grants[w] + 1;
        model_ptr = (w + 1) % NREQ;

        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || gnt !== '0 || ack !== '0) begin
            errors++;
            $display("[TB] FAIL %s idle: busy=%b gnt=%b ack=%b required 0", name, busy, gnt, ack);
        end
    endtask

    task automatic drain();
        int w;
        for (int k = 0; k < NREQ; k++) begin
            bit any_p;
            any_p = 1'b0;
            for (int i = 0; i < NREQ; i++) any_p |= pend[i];
            if (any_p) run_txn("drain", 0, w);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (gnt !== '0 || ack !== '0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: gnt=%b ack=%b busy=%b required 0", gnt, ack, busy);
        end
        checks++;
        if (ram_en !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0 || rdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: en=%b we=%b addr=%h wdata=%h rdata=%h required 0",
                     ram_en, ram_we, ram_addr, ram_wdata, rdata);
        end
        rst_n = 1'b1;
        model_ptr = 0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            waits[i] = 0;
        end
    endtask

    task automatic test_single_write();
        int w;
        raise(0, 1'b1, 8'h05, 8'hA5);
        run_txn("single_write", 0, w);
        checks++;
        if (mem[8'h05] !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL single_write_mem: mem[05]=%h required a5", mem[8'h05]);
        end
    endtask

    task automatic test_single_read();
        int w;
        raise(1, 1'b0, 8'h05, 8'h00);
        run_txn("single_read", 0, w);
    endtask

    task automatic test_read_drop();
        int w;
        raise(2, 1'b0, 8'h05, 8'h3C);
        run_txn("read_drop", 3, w);
    endtask

    task automatic test_fairness();
        int w;
        for (int i = 0; i < NREQ; i++) begin
            grants[i] = 0;
            raise_random(i);
        end
        for (int t = 0; t < 2 * NREQ; t++) begin
            run_txn("fairness", 0, w);
            if (w >= 0) raise_random(w);
        end
        for (int i = 0; i < NREQ; i++) begin
            checks++;
            if (grants[i] != 2) begin
                errors++;
                $display("[TB] FAIL fairness_count: req %0d got %0d grants required 2", i, grants[i]);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int w;
        for (int t = 0; t < 40; t++) begin
            bit any_p;
            any_p = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) raise_random(i);
                any_p |= pend[i];
            end
            if (!any_p) raise_random(int'($urandom_range(0, NREQ - 1)));
            run_txn("random", int'($urandom_range(0, 3)), w);
        end
        drain();
    endtask

    task automatic test_reset_mid_read();
        int w;
        raise(model_ptr, 1'b0, 8'h05, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        req   = '0;
        @(posedge clk); #1;
        checks++;
        if (ack !== '0 || gnt !== '0 || busy !== 1'b0 || ram_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_read: ack=%b gnt=%b busy=%b ram_en=%b required 0", ack, gnt, busy, ram_en);
        end
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        model_ptr = 0;
        for (int k = 0; k < RD_LAT + 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if (ack !== '0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_no_ack: ack=%b busy=%b required 0", ack, busy);
            end
        end
        raise(3, 1'b1, 8'h07, 8'h5A);
        run_txn("post_reset_write", 0, w);
        raise(2, 1'b0, 8'h05, 8'h00);
        run_txn("post_reset_read5", 0, w);
        raise(1, 1'b0, 8'h07, 8'h00);
        run_txn("post_reset_read7", 0, w);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        for (int i = 0; i < NREQ; i++) grants[i] = 0;
        test_reset();
        test_single_write();
        test_single_read();
        test_read_drop();
        test_fairness();
        test_back_to_back();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter that shares one single-port synchronous RAM (clk, we, 8-bit addr style) between NREQ requesters.
- Sequences each access through a small FSM and drives the RAM enable, write enable, address and write data.
- Returns a one-cycle ack to the winning requester, with read data for reads.
- Sits between the requesting engines and the RAM instance at the top level.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 8, address width.
- DW, 8, data width.
- RD_LAT, 1, RAM read latency in cycles from the ram_en cycle to valid ram_rdata (1..4).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous reset, active-low.
- req  in  NREQ  per-requester request level; held until ack.
- req_we  in  NREQ  per-requester write (1) / read (0); stable while req high.
- req_addr  in  NREQ*AW  packed addresses; requester i at bits [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data; same packing as req_addr.
- gnt  out  NREQ  one-hot grant, high from the ISSUE cycle through the ACK cycle.
- ack  out  NREQ  one-hot, one-cycle completion pulse.
- rdata  out  DW  read data; valid only with ack for a read.
- busy  out  1  high whenever state != IDLE.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data.

Behaviour:
- All outputs are registered.
- Reset (rst_n low at a clock edge):
  - state=IDLE; gnt, ack, ram_en, ram_we and busy = 0.
  - ram_addr, ram_wdata, rdata = 0.
  - Round-robin pointer = 0.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req bit is high, pick the winner by round-robin, starting the search at the pointer and wrapping modulo NREQ.
  - Register gnt, ram_addr, ram_wdata and ram_we from the winner; set ram_en=1; go to ISSUE.
  - If no req bit is high, stay in IDLE.
- ISSUE (exactly one cycle, ram_en=1):
  - Write: go to ACK.
  - Read: go to WAIT with the wait counter loaded to RD_LAT-1.
  - ram_en and ram_we drop at the end of ISSUE.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture ram_rdata into rdata and go to ACK.
  - Counter width is clog2(RD_LAT)+1.
- ACK (one cycle):
  - ack[winner]=1, gnt held.
  - Pointer = (winner+1) mod NREQ.
  - Next state is IDLE; gnt clears entering IDLE.
- Latency, with req sampled in IDLE at edge k:
  - Write: ISSUE in cycle k+1, ack in k+2.
  - Read: ISSUE in k+1, WAIT during k+2..k+1+RD_LAT, ack in k+2+RD_LAT.
- Requester protocol: deassert req (or present a new request) in the cycle after ack. IDLE samples req only after ACK, so there is no double service.
- Throughput: one write per 3 cycles; one read per 3+RD_LAT cycles.
- Simultaneous requests: the lowest index at or after the pointer wins. A requester that stays pending waits at most NREQ-1 other grants.
- req dropped mid-transaction: the transaction still completes and ack still pulses. No abort.
- req_addr, req_wdata and req_we changing after IDLE sampling are ignored; values are latched.
- Reset mid-operation: the next cycle is IDLE with all outputs zero and no ack issued. A pending write already strobed in ISSUE is not retracted.
- rdata holds its last captured value outside read ack and is don't-care for write acks.

Decomposition:
- Package ram_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, ACK).
  - Default constants for AW, DW, NREQ, RD_LAT.
  - A clog2 helper function.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ], ptr.
  - Outputs: one-hot win, win_idx, any.
- Everything else (FSM, counter, data muxing) stays in ram_port_arbiter.

Test Plan:
- Single write: req=01, we=1, addr=0x05, wdata=0xA5 at edge k -> ram_en=ram_we=1 and ram_addr=0x05 in k+1; ack=01 in k+2; RAM location 0x05 = 0xA5.
- Single read, RD_LAT=1, after the write above: req=10, we=0, addr=0x05 -> ram_en in k+1, ack=10 with rdata=0xA5 in k+3.
- Contention: req=11 held continuously from reset (requesters re-raise after each ack) -> grant order 0,1,0,1; exactly one ack bit per transaction; gnt always one-hot.
- Round-robin fairness, NREQ=4: req=1111 held -> grant sequence 0,1,2,3,0; requester 3 waits no more than 3 grants.
- Reset mid-read, RD_LAT=3: assert rst_n=0 during WAIT -> next cycle state IDLE, ack=0, gnt=0, busy=0; a later read still returns correct data.
- Read latency, RD_LAT=2: read of 0x05 -> ack in k+4 with rdata=0xA5; req dropped during WAIT still yields ack.
